fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage with IF/ID register. Sits directly upstream of decode, where the control unit and the immediate extender live.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ready, rvalid handshake.
- Buffers one response in a skid entry and presents a registered instruction with pre-split fields (op, rs, rt, rd, shamt, funct, imm16) to decode.
- Handles decode stall and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address, word aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target.
- stall  in  1  decode cannot accept a new instruction.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pc  out  ADDR_W  PC of the held instruction.
- id_pc4  out  ADDR_W  id_pc+4.
- id_instr  out  32  raw instruction.
- id_op  out  6  instr[31:26].
- id_rs  out  5  instr[25:21].
- id_rt  out  5  instr[20:16].
- id_rd  out  5  instr[15:11].
- id_shamt  out  5  instr[10:6].
- id_funct  out  6  instr[5:0].
- id_imm16  out  16  instr[15:0]; feeds the extender.

Behaviour:
- Reset (rstn=0 at an edge):
  - pc=RESET_PC, state=REQ, skid empty, id_valid=0, all id_* outputs=0.
  - imem_req=0 during any cycle in which rstn=0.
  - An imem_rvalid arriving after reset while in REQ is ignored.
- ID slot is free when !id_valid || !stall. Decode consumes when id_valid && !stall.
- State REQ:
  - imem_req=1 only while the slot is free or will be free, i.e. the skid is empty. imem_addr=pc.
  - When imem_req && imem_ready: go WAIT.
  - The address may change while not yet accepted.
- State WAIT, on imem_rvalid:
  - If the slot is free: load IF/ID (id_valid=1, id_pc=pc, fields from rdata), pc<=pc+4, go REQ.
  - Otherwise: store rdata into the skid, pc<=pc+4, go FULL.
- State FULL: when the slot frees, move the skid into IF/ID and go REQ. No request is issued in FULL.
- State DROP: wait for imem_rvalid, discard the data, go REQ.
- Fetch latency: the instruction appears in IF/ID on the edge after the rvalid cycle. Minimum 2 cycles per instruction with a 1-cycle memory: REQ(ready), WAIT(rvalid).
- Consumed without refill: id_valid<=0 next edge. Stall holds all id_* stable.
- Redirect has the highest priority, in every state:
  - id_valid<=0 and skid cleared.
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - From WAIT, or from REQ with imem_ready the same cycle: go DROP (stale response outstanding).
  - From REQ without ready, or from FULL: go REQ.
  - From DROP: stay in DROP with the new pc.
- Redirect coinciding with rvalid in WAIT: the response is discarded, state goes to REQ (the outstanding beat is consumed), pc=redirect target.
- PC wraps modulo 2^ADDR_W: 32'hFFFF_FFFC+4 -> 0.
- imem_addr[1:0] is always 00.

Decomposition:
- Shared define file (ctrl_encode_def.v): fetch state encodings (REQ, WAIT, FULL, DROP), instruction field bit positions, default RESET_PC.
- Sub-module instr_split: combinational 32-bit word -> op/rs/rt/rd/shamt/funct/imm16. Used for both the IF/ID load and decode-side checks.

Test Plan:
- Reset then 1-cycle memory returning 0x3C011234 at 0x0, no stall:
  - imem_addr = 0x0 then 0x4.
  - id_valid rises with id_pc=0, id_op=0x0F, id_rt=1, id_imm16=0x1234.
- stall=1 for 4 cycles while rvalid arrives:
  - IF/ID holds the old instruction and the skid captures the new one. No imem_req in FULL.
  - stall=0 -> the skid instruction appears next edge, pc advanced exactly once.
- Redirect to 0x0000_0103 while in WAIT:
  - The next rvalid (0xDEADBEEF) is dropped and never appears on id_instr.
  - The following request has imem_addr=0x0000_0100. id_valid=0 the edge after the redirect.
- Redirect coincident with imem_ready in REQ: goes to DROP. Redirect coincident with rvalid in WAIT: goes to REQ with the new pc and no extra beat waited.
- RESET_PC=0xFFFF_FFFC: the second fetch address is 0x0000_0000.
- rstn=0 mid-WAIT:
  - Outputs go to 0 on that edge.
  - A late rvalid after reset is ignored.
  - The first new request is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encodings, instruction field
// positions and the default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_instr_split.sv
// Combinational split of a 32-bit instruction word into its decode fields.
module instr_split
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign op    = instr[OP_LSB +: 6];
    assign rs    = instr[RS_LSB +: 5];
    assign rt    = instr[RT_LSB +: 5];
    assign rd    = instr[RD_LSB +: 5];
    assign shamt = instr[SHAMT_LSB +: 5];
    assign funct = instr[FUNCT_LSB +: 6];
    assign imm16 = instr[IMM_LSB +: 16];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, one skid
// entry and the IF/ID register feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_op,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [15:0]       id_imm16,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [31:0]       skid_instr;
    logic              skid_valid;
    logic              slot_free;
    logic              accept;
    logic [ADDR_W-1:0] pc_next4;

    // Handshake: a request is transferred on a rising edge where imem_req and
    // imem_ready are both high; exactly one rvalid beat returns per transfer.
    assign slot_free = !id_valid || !stall;
    assign imem_req  = rstn && (state == ST_REQ) && !skid_valid;
    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc & ALIGN_MASK;
    assign pc_next4  = pc + PC_STEP;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_REQ;
            pc         <= RESET_PC & ALIGN_MASK;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_pc4     <= '0;
            id_instr   <= '0;
        end else if (redirect_valid) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= redirect_pc & ALIGN_MASK;
            // A beat still in flight must be swallowed in DROP; a beat arriving
            // this very cycle (WAIT or DROP) is already the stale one.
            case (state)
                ST_REQ:  state <= accept ? ST_DROP : ST_REQ;
                ST_WAIT: state <= imem_rvalid ? ST_REQ : ST_DROP;
                ST_FULL: state <= ST_REQ;
                ST_DROP: state <= imem_rvalid ? ST_REQ : ST_DROP;
                default: state <= ST_REQ;
            endcase
        end else begin
            if (id_valid && !stall) begin
                id_valid <= 1'b0;
            end
            case (state)
                ST_REQ: begin
                    if (accept) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc <= pc_next4;
                        if (slot_free) begin
                            id_valid <= 1'b1;
                            id_pc    <= pc;
                            id_pc4   <= pc_next4;
                            id_instr <= imem_rdata;
                            state    <= ST_REQ;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            state      <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (slot_free) begin
                        id_valid   <= 1'b1;
                        id_pc      <= skid_pc;
                        id_pc4     <= skid_pc + PC_STEP;
                        id_instr   <= skid_instr;
                        skid_valid <= 1'b0;
                        state      <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    instr_split u_split (
        .instr (id_instr),
        .op    (id_op),
        .rs    (id_rs),
        .rt    (id_rt),
        .rd    (id_rd),
        .shamt (id_shamt),
        .funct (id_funct),
        .imm16 (id_imm16)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a hand-written flush sequence
// and a randomized run against an instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;

    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_pc4, id_instr;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16;
    logic [1:0]  dbg_state;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_pc4, w_instr;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;
    logic [1:0]  w_state;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
        .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
        .dbg_state(dbg_state)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rstn(rstn), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(w_valid), .id_pc(w_pc), .id_pc4(w_pc4), .id_instr(w_instr),
        .id_op(w_op), .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd),
        .id_shamt(w_shamt), .id_funct(w_funct), .id_imm16(w_imm16),
        .dbg_state(w_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w);
        chk({tag, ".op"},    32'(id_op),    32'(w[31:26]));
        chk({tag, ".rs"},    32'(id_rs),    32'(w[25:21]));
        chk({tag, ".rt"},    32'(id_rt),    32'(w[20:16]));
        chk({tag, ".rd"},    32'(id_rd),    32'(w[15:11]));
        chk({tag, ".shamt"}, 32'(id_shamt), 32'(w[10:6]));
        chk({tag, ".funct"}, 32'(id_funct), 32'(w[5:0]));
        chk({tag, ".imm16"}, 32'(id_imm16), 32'(w[15:0]));
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input logic rn, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic st, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rstn = rn; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        stall = st; redirect_valid = redir; redirect_pc = rpc;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rstn, ready, rvalid, stall, redir;
        logic [31:0] rdata, rpc;
        logic        exp_req;
        logic [31:0] exp_addr, exp_addr2;
        logic [1:0]  exp_state;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_instr;
        logic        chk_all;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rn, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic redir, input logic [31:0] rpc,
                       input logic ereq, input logic [31:0] eaddr, input logic [31:0] eaddr2,
                       input logic [1:0] est, input logic ev, input logic [31:0] epc,
                       input logic [31:0] ei, input logic call);
        vec_t v;
        v.rstn = rn; v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.stall = st;
        v.redir = redir; v.rpc = rpc; v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_addr2 = eaddr2; v.exp_state = est; v.exp_valid = ev; v.exp_pc = epc;
        v.exp_instr = ei; v.chk_all = call;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        vec_t v;
        string tag;
        row(0,0,0,0,          0,0,0,      0,0,0,               S_REQ, 0,0,0,1);
        row(1,1,0,0,          0,0,0,      1,0,32'hFFFF_FFFC,   S_WAIT,0,0,0,0);
        row(1,0,1,32'h3C011234,0,0,0,     0,0,0,               S_REQ, 1,0,32'h3C011234,0);
        row(1,1,0,0,          0,0,0,      1,4,0,               S_WAIT,0,0,0,0);
        row(1,0,1,32'h012A5820,1,0,0,     0,0,0,               S_REQ, 1,4,32'h012A5820,0);
        row(1,1,0,0,          1,0,0,      1,8,4,               S_WAIT,1,4,32'h012A5820,0);
        row(1,0,1,32'h8C430004,1,0,0,     0,0,0,               S_FULL,1,4,32'h012A5820,0);
        row(1,1,0,0,          1,0,0,      0,0,0,               S_FULL,1,4,32'h012A5820,0);
        row(1,0,0,0,          1,0,0,      0,0,0,               S_FULL,1,4,32'h012A5820,0);
        row(1,0,0,0,          0,0,0,      0,0,0,               S_REQ, 1,8,32'h8C430004,0);
        row(1,1,0,0,          1,0,0,      1,32'hC,8,           S_WAIT,1,8,32'h8C430004,0);
        row(1,0,0,0,          1,1,32'h103,0,0,0,               S_DROP,0,0,0,0);
        row(1,0,1,32'hDEADBEEF,1,0,0,     0,0,0,               S_REQ, 0,0,0,0);
        row(1,1,0,0,          0,0,0,      1,32'h100,32'h100,   S_WAIT,0,0,0,0);
        row(1,0,1,32'h0BADF00D,0,1,32'h200,0,0,0,              S_REQ, 0,0,0,0);
        row(1,1,0,0,          0,1,32'h300,1,32'h200,32'h200,   S_DROP,0,0,0,0);
        row(1,0,0,0,          0,0,0,      0,0,0,               S_DROP,0,0,0,0);
        row(1,0,0,0,          0,1,32'h404,0,0,0,               S_DROP,0,0,0,0);
        row(1,0,1,32'h11111111,0,0,0,     0,0,0,               S_REQ, 0,0,0,0);
        row(1,0,0,0,          0,0,0,      1,32'h404,32'h404,   S_REQ, 0,0,0,0);
        row(1,0,0,0,          0,1,32'h500,1,32'h404,32'h404,   S_REQ, 0,0,0,0);
        row(1,1,0,0,          0,0,0,      1,32'h500,32'h500,   S_WAIT,0,0,0,0);
        row(1,0,1,32'h22222222,0,0,0,     0,0,0,               S_REQ, 1,32'h500,32'h22222222,0);
        row(1,1,0,0,          0,0,0,      1,32'h504,32'h504,   S_WAIT,0,0,0,0);
        row(0,0,0,0,          0,0,0,      0,0,0,               S_REQ, 0,0,0,1);
        row(1,0,1,32'h33333333,0,0,0,     1,0,32'hFFFF_FFFC,   S_REQ, 0,0,0,0);
        row(1,1,0,0,          0,0,0,      1,0,32'hFFFF_FFFC,   S_WAIT,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            apply(v.rstn, v.ready, v.rvalid, v.rdata, v.stall, v.redir, v.rpc);
            chk({tag, ".imem_req"}, 32'(imem_req), 32'(v.exp_req));
            if (v.exp_req) begin
                chk({tag, ".imem_addr"}, imem_addr, v.exp_addr);
                chk({tag, ".wrap_addr"}, w_addr, v.exp_addr2);
            end
            edge_wait();
            chk({tag, ".state"}, 32'(dbg_state), 32'(v.exp_state));
            chk({tag, ".id_valid"}, 32'(id_valid), 32'(v.exp_valid));
            if (v.exp_valid || v.chk_all) begin
                chk({tag, ".id_pc"}, id_pc, v.exp_pc);
                chk({tag, ".id_instr"}, id_instr, v.exp_instr);
                chk({tag, ".id_pc4"}, id_pc4, v.exp_valid ? v.exp_pc + 32'd4 : 32'd0);
                chk_fields(tag, v.exp_instr);
            end
        end
    endtask

    // Redirect while the skid is full: skid content must never reach decode.
    task automatic run_full_flush();
        apply(1,0,1,32'h0000_0044,0,0,0);
        edge_wait();
        chk("ff.load_valid", 32'(id_valid), 32'd1);
        chk("ff.load_instr", id_instr, 32'h0000_0044);
        apply(1,1,0,0,1,0,0);
        edge_wait();
        apply(1,0,1,32'h0000_0055,1,0,0);
        edge_wait();
        chk("ff.full_state", 32'(dbg_state), 32'(S_FULL));
        apply(1,0,0,0,1,1,32'h8000_0002);
        chk("ff.no_req_full", 32'(imem_req), 32'd0);
        edge_wait();
        chk("ff.redir_state", 32'(dbg_state), 32'(S_REQ));
        chk("ff.redir_valid", 32'(id_valid), 32'd0);
        apply(1,0,0,0,0,0,0);
        chk("ff.req", 32'(imem_req), 32'd1);
        chk("ff.addr", imem_addr, 32'h8000_0000);
        edge_wait();
        chk("ff.skid_flushed", 32'(id_valid), 32'd0);
    endtask

    // Reference: decode must see the word mem_word(pc) for consecutive PCs,
    // restarting at the aligned target after each redirect.
    task automatic run_random(input int cycles);
        logic        busy = 1'b0;
        int          lat = 0;
        logic [31:0] resp_addr = '0;
        logic        hold_chk = 1'b0;
        logic [31:0] held_pc = '0, held_instr = '0, nxt;
        int          consumed = 0;

        apply(0,0,0,0,0,0,0);
        edge_wait();
        exp_q.delete();
        exp_q.push_back(32'h0);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (hold_chk) begin
                chk("rnd.hold_valid", 32'(id_valid), 32'd1);
                chk("rnd.hold_pc", id_pc, held_pc);
                chk("rnd.hold_instr", id_instr, held_instr);
            end
            rstn = 1'b1;
            imem_rvalid = 1'b0;
            if (busy) begin
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem_word(resp_addr);
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end
            imem_ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | $urandom_range(0, 3)
                                                      : $urandom_range(0, 32'h0000_0FFF);
            #1;
            if (imem_req) begin
                chk("rnd.addr_align", 32'(imem_addr[1:0]), 32'd0);
                chk("rnd.single_outstanding", 32'(busy), 32'd0);
                if (imem_ready) begin
                    busy = 1'b1;
                    resp_addr = imem_addr;
                    lat = $urandom_range(0, 2);
                end
            end
            if (id_valid && !stall) begin
                chk("rnd.id_pc", id_pc, exp_q[0]);
                chk("rnd.id_instr", id_instr, mem_word(id_pc));
                chk("rnd.id_pc4", id_pc4, id_pc + 32'd4);
                chk_fields("rnd", mem_word(id_pc));
                nxt = exp_q.pop_front() + 32'd4;
                exp_q.push_back(nxt);
                consumed++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'd3);
            end
            hold_chk = id_valid && stall && !redirect_valid;
            held_pc = id_pc;
            held_instr = id_instr;
        end
        chk("rnd.progress", 32'(consumed >= 100), 32'd1);
    endtask

    initial begin
        run_table();
        run_full_flush();
        run_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
